cell_segmenter: RTL and testbench
=================================

CELL_SEGMENTER -- requirements
Module: cell_segmenter

Interface
REQ-001 clk  input  1  single clock for all logic.
REQ-002 rstn  input  1  reset; asynchronous assert, active-low.
REQ-003 s_data  input  128  frame word from the ingress/lookup stage.
REQ-004 s_valid  input  1  s_data valid.
REQ-005 s_sof  input  1  first word of frame; qualified by s_valid.
REQ-006 s_eof  input  1  last word of frame; qualified by s_valid; may coincide with s_sof.
REQ-007 s_portmap  input  4  destination port bitmap; sampled only on the accepted sof word.
REQ-008 s_ready  output  1  word accepted when s_valid & s_ready.
REQ-009 cell_data_fifo_din  output  128  word to the switch core cell data FIFO.
REQ-010 cell_data_fifo_wr  output  1  one-cycle write strobe per word.
REQ-011 cell_ptr_fifo_din  output  16  frame descriptor: [15:12]=0, [11:8]=portmap, [7:6]=0, [5:0]=cell count.
REQ-012 cell_ptr_fifo_wr  output  1  one-cycle descriptor write strobe.
REQ-013 cell_bp  input  1  switch core backpressure (registered on core side).
REQ-014 err_pulse  output  1  one-cycle pulse per protocol error or truncation.
REQ-015 drop_cnt  output  16  saturating count of discarded frames.

Function
REQ-016 Cell = 4 consecutive 128-bit words (64 B); frame cell count = ceil(words/4); range 1..63.
REQ-017 States: IDLE, DATA, PAD, PTR, DISCARD; all outputs registered.
REQ-018 s_ready: IDLE = !cell_bp; DATA = 1; DISCARD = 1; PAD = 0; PTR = 0.
REQ-019 cell_bp is sampled only in IDLE; a frame already started is never stalled by cell_bp (core FIFO headroom covers one frame).
REQ-020 IDLE, accepted word with s_sof and s_portmap != 0: latch portmap, word index = 0, cell count = 1, write the word; go to DATA (or to the end-of-frame path if s_eof).
REQ-021 IDLE, accepted word with s_sof and s_portmap == 0: no data write; drop_cnt +1; DISCARD (return to IDLE the same cycle if s_eof).
REQ-022 IDLE, accepted word without s_sof: discard the word; err_pulse; remain in IDLE.
REQ-023 Latency: a word accepted in cycle n appears on cell_data_fifo_din with cell_data_fifo_wr = 1 in cycle n+1.
REQ-024 DATA: each accepted word is written; word index increments mod 4; cell count increments when the index wraps 3->0. s_sof in DATA is ignored and the word is treated as data.
REQ-025 End of frame with final word index 3: go to PTR.
REQ-026 End of frame with final word index k < 3: go to PAD; write (3-k) all-zero words on consecutive cycles; then go to PTR.
REQ-027 PTR: cell_ptr_fifo_wr = 1 for exactly one cycle, in the cycle immediately following the last data/pad write; then go to IDLE.
REQ-028 Truncation: word 252 (cell 63, index 3) accepted without s_eof: treat as eof; err_pulse; go to PTR with count 63; then DISCARD until s_eof.
REQ-029 DISCARD: accept and drop words; on accepted s_eof go to IDLE.
REQ-030 drop_cnt saturates at 16'hFFFF.
REQ-031 Gaps in s_valid in DATA are allowed; the frame resumes without padding.

Reset
REQ-032 rstn low: state = IDLE; s_ready, cell_data_fifo_wr, cell_ptr_fifo_wr and err_pulse = 0; din buses, drop_cnt and internal counters = 0.
REQ-033 Reset mid-frame abandons the frame with no descriptor write; words already in the core FIFO are flushed by the core's own reset.

Verification
REQ-034 5-word frame, portmap 4'b0101, cell_bp = 0 -> 8 data writes (5 data + 3 zero) on consecutive cycles, then descriptor 16'h0502.
REQ-035 Single word with s_sof = s_eof = 1, portmap 4'b1000 -> 4 data writes, then descriptor 16'h0801; s_ready = 0 for 4 cycles.
REQ-036 cell_bp = 1 in IDLE with sof pending -> s_ready = 0, no writes; cell_bp falls -> frame accepted; cell_bp raised mid-frame -> no stall.
REQ-037 portmap = 0, 10-word frame -> no data or descriptor writes; drop_cnt = 1; next valid frame processed normally.
REQ-038 260-word frame without eof until word 260 -> 252 data writes, descriptor [5:0] = 63, one err_pulse, remaining 8 words dropped, return to IDLE.
REQ-039 rstn asserted during word 3 of a frame -> all outputs 0 immediately; next sof after release produces a correct frame.

Source files
------------

// File: rtl/cell_segmenter.sv
// Splits ingress frames into 64-byte cells (four 128-bit words), zero-pads the last cell
// and emits one descriptor per frame carrying the destination portmap and cell count.
module cell_segmenter (
    input  logic         clk,
    input  logic         rstn,
    input  logic [127:0] s_data,
    input  logic         s_valid,
    input  logic         s_sof,
    input  logic         s_eof,
    input  logic [3:0]   s_portmap,
    output logic         s_ready,
    output logic [127:0] cell_data_fifo_din,
    output logic         cell_data_fifo_wr,
    output logic [15:0]  cell_ptr_fifo_din,
    output logic         cell_ptr_fifo_wr,
    input  logic         cell_bp,
    output logic         err_pulse,
    output logic [15:0]  drop_cnt
);

    localparam int unsigned DATA_W    = 128;
    localparam int unsigned PORT_W    = 4;
    localparam int unsigned IDX_W     = 2;
    localparam int unsigned CNT_W     = 6;
    localparam int unsigned DROP_W    = 16;
    localparam int unsigned MAX_CELLS = 63;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_DATA,
        ST_PAD,
        ST_PTR,
        ST_DISCARD
    } state_t;

    state_t              state;
    logic [PORT_W-1:0]   portmap;
    logic [IDX_W-1:0]    idx;      // index the next written word will occupy within its cell
    logic [CNT_W-1:0]    cnt;      // cell number of the most recently written word
    logic                trunc;
    logic                accept;

    assign accept = s_valid & s_ready;

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state              <= ST_IDLE;
            portmap            <= '0;
            idx                <= '0;
            cnt                <= '0;
            trunc              <= 1'b0;
            s_ready            <= 1'b0;
            cell_data_fifo_din <= '0;
            cell_data_fifo_wr  <= 1'b0;
            cell_ptr_fifo_din  <= '0;
            cell_ptr_fifo_wr   <= 1'b0;
            err_pulse          <= 1'b0;
            drop_cnt           <= '0;
        end else begin
            cell_data_fifo_wr <= 1'b0;
            cell_ptr_fifo_wr  <= 1'b0;
            err_pulse         <= 1'b0;

            case (state)
                ST_IDLE: begin
                    s_ready <= !cell_bp;
                    if (accept) begin
                        if (!s_sof) begin
                            err_pulse <= 1'b1;
                        end else if (s_portmap == '0) begin
                            // Frame with no destination is counted and swallowed
                            if (drop_cnt != {DROP_W{1'b1}})
                                drop_cnt <= drop_cnt + DROP_W'(1);
                            if (!s_eof) begin
                                state   <= ST_DISCARD;
                                s_ready <= 1'b1;
                            end
                        end else begin
                            portmap            <= s_portmap;
                            cnt                <= CNT_W'(1);
                            idx                <= IDX_W'(1);
                            trunc              <= 1'b0;
                            cell_data_fifo_din <= s_data;
                            cell_data_fifo_wr  <= 1'b1;
                            if (s_eof) begin
                                state   <= ST_PAD;
                                s_ready <= 1'b0;
                            end else begin
                                state   <= ST_DATA;
                                s_ready <= 1'b1;
                            end
                        end
                    end
                end

                ST_DATA: begin
                    if (accept) begin
                        cell_data_fifo_din <= s_data;
                        cell_data_fifo_wr  <= 1'b1;
                        idx                <= idx + IDX_W'(1);
                        if (idx == '0)
                            cnt <= cnt + CNT_W'(1);
                        if (s_eof) begin
                            s_ready <= 1'b0;
                            state   <= (idx == IDX_W'(3)) ? ST_PTR : ST_PAD;
                        end else if (idx == IDX_W'(3) && cnt == CNT_W'(MAX_CELLS)) begin
                            // Descriptor field is full: close the frame here, drop the rest
                            err_pulse <= 1'b1;
                            trunc     <= 1'b1;
                            s_ready   <= 1'b0;
                            state     <= ST_PTR;
                        end
                    end
                end

                ST_PAD: begin
                    cell_data_fifo_din <= '0;
                    cell_data_fifo_wr  <= 1'b1;
                    idx                <= idx + IDX_W'(1);
                    if (idx == IDX_W'(3))
                        state <= ST_PTR;
                end

                ST_PTR: begin
                    cell_ptr_fifo_din <= {4'b0000, portmap, 2'b00, cnt};
                    cell_ptr_fifo_wr  <= 1'b1;
                    trunc             <= 1'b0;
                    idx               <= '0;
                    if (trunc) begin
                        state   <= ST_DISCARD;
                        s_ready <= 1'b1;
                    end else begin
                        state   <= ST_IDLE;
                        s_ready <= !cell_bp;
                    end
                end

                ST_DISCARD: begin
                    s_ready <= 1'b1;
                    if (accept && s_eof) begin
                        state   <= ST_IDLE;
                        s_ready <= !cell_bp;
                    end
                end

                default: begin
                    state   <= ST_IDLE;
                    s_ready <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_cell_segmenter.sv
// Self-checking bench for cell_segmenter: table of frame vectors, directed corner cases and
// random frames compared against a frame-level model of the cell/pad/descriptor rules.
module tb_cell_segmenter;

    logic         clk = 1'b0;
    logic         rstn = 1'b0;
    logic [127:0] s_data = '0;
    logic         s_valid = 1'b0;
    logic         s_sof = 1'b0;
    logic         s_eof = 1'b0;
    logic [3:0]   s_portmap = '0;
    logic         s_ready;
    logic [127:0] cell_data_fifo_din;
    logic         cell_data_fifo_wr;
    logic [15:0]  cell_ptr_fifo_din;
    logic         cell_ptr_fifo_wr;
    logic         cell_bp = 1'b0;
    logic         err_pulse;
    logic [15:0]  drop_cnt;

    cell_segmenter dut (
        .clk                (clk),
        .rstn               (rstn),
        .s_data             (s_data),
        .s_valid            (s_valid),
        .s_sof              (s_sof),
        .s_eof              (s_eof),
        .s_portmap          (s_portmap),
        .s_ready            (s_ready),
        .cell_data_fifo_din (cell_data_fifo_din),
        .cell_data_fifo_wr  (cell_data_fifo_wr),
        .cell_ptr_fifo_din  (cell_ptr_fifo_din),
        .cell_ptr_fifo_wr   (cell_ptr_fifo_wr),
        .cell_bp            (cell_bp),
        .err_pulse          (err_pulse),
        .drop_cnt           (drop_cnt)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int err_seen = 0;
    int exp_drop = 0;

    logic [127:0] got_q[$];
    int           got_cyc[$];
    logic [15:0]  desc_q[$];
    int           desc_cyc[$];

    always @(posedge clk) cyc <= cyc + 1;

    // Output monitor, sampled mid-cycle
    always @(negedge clk) begin
        if (cell_data_fifo_wr) begin
            got_q.push_back(cell_data_fifo_din);
            got_cyc.push_back(cyc);
        end
        if (cell_ptr_fifo_wr) begin
            desc_q.push_back(cell_ptr_fifo_din);
            desc_cyc.push_back(cyc);
        end
        if (err_pulse) err_seen++;
    end

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%0h exp=%0h", name, got, exp);
        end
    endtask

    task automatic clear_mon();
        got_q.delete();
        got_cyc.delete();
        desc_q.delete();
        desc_cyc.delete();
    endtask

    // Present one word and hold it until accepted (bounded wait)
    task automatic drive_word(input logic [127:0] d, input logic sof, input logic eof,
                              input logic [3:0] pm, output int acc_cyc, output bit ok);
        int t = 0;
        ok = 1'b0;
        acc_cyc = 0;
        @(negedge clk);
        s_data = d; s_sof = sof; s_eof = eof; s_portmap = pm; s_valid = 1'b1;
        while (!s_ready && t < 400) begin
            @(negedge clk);
            t++;
        end
        if (s_ready) begin
            acc_cyc = cyc;
            @(posedge clk);
            ok = 1'b1;
        end else begin
            chk("accept_timeout", 0, 1);
        end
        #1 s_valid = 1'b0;
    endtask

    // Send a frame, build the expected cell stream from the framing rules, compare.
    task automatic run_frame(input int fid, input int len, input logic [3:0] pm,
                             input int gap_pct, input bit junk_sof,
                             output int nwr, output logic [15:0] desc);
        logic [127:0] words[$];
        logic [127:0] exp_q[$];
        logic [127:0] w;
        int  acc, first_acc, err_base, ncells, kept, bad;
        bit  ok, sof;
        logic [15:0] exp_desc;
        clear_mon();
        err_base = err_seen;
        first_acc = 0;
        for (int i = 0; i < len; i++) begin
            if (gap_pct > 0 && $urandom_range(99) < gap_pct)
                repeat ($urandom_range(1, 3)) @(negedge clk);
            w = {32'(fid), 32'(i), $urandom(), $urandom()};
            sof = (i == 0) || (junk_sof && $urandom_range(7) == 0);
            drive_word(w, sof, i == len - 1, (i == 0) ? pm : 4'($urandom()), acc, ok);
            if (!ok) break;
            if (i == 0) first_acc = acc;
            words.push_back(w);
        end
        repeat (12) @(negedge clk);

        // Reference: up to 63 cells kept, last cell zero-filled, descriptor per kept frame
        exp_desc = '0;
        if (pm == 4'd0) begin
            exp_drop = (exp_drop < 65535) ? exp_drop + 1 : 65535;
        end else begin
            kept = (len > 252) ? 252 : len;
            ncells = (kept + 3) / 4;
            for (int i = 0; i < kept; i++) exp_q.push_back(words[i]);
            while (exp_q.size() < ncells * 4) exp_q.push_back('0);
            exp_desc = {4'b0, pm, 2'b0, 6'(ncells)};
        end

        chk("write_count", got_q.size(), exp_q.size());
        bad = 0;
        for (int i = 0; i < exp_q.size(); i++)
            if (i >= got_q.size() || got_q[i] !== exp_q[i]) bad++;
        chk("data_words", bad, 0);
        chk("desc_count", desc_q.size(), (pm != 0) ? 1 : 0);
        if (desc_q.size() > 0 && got_q.size() > 0) begin
            chk("desc_value", desc_q[0], exp_desc);
            chk("desc_after_last_write", desc_cyc[0], got_cyc[got_q.size() - 1] + 1);
            chk("first_write_latency", got_cyc[0], first_acc + 1);
            if (len <= 252 && len >= 1 && got_q.size() == exp_q.size())
                chk("pad_consecutive", got_cyc[exp_q.size() - 1] - got_cyc[len - 1],
                    exp_q.size() - len);
        end
        chk("err_pulses", err_seen - err_base, (pm != 0 && len > 252) ? 1 : 0);
        chk("drop_cnt", drop_cnt, exp_drop);
        nwr = got_q.size();
        desc = (desc_q.size() > 0) ? desc_q[0] : 16'h0000;
    endtask

    typedef struct {
        int         len;
        logic [3:0] pm;
        int         gap;
        int         exp_nwr;
        logic [15:0] exp_desc;
    } vec_t;

    vec_t vecs[$];

    initial begin
        int nwr, acc, base;
        bit ok;
        logic [15:0] desc;

        vecs.push_back('{5,   4'b0101, 0,  8,   16'h0502});
        vecs.push_back('{1,   4'b1000, 0,  4,   16'h0801});
        vecs.push_back('{4,   4'b0011, 0,  4,   16'h0301});
        vecs.push_back('{8,   4'b1111, 20, 8,   16'h0F02});
        vecs.push_back('{9,   4'b0001, 0,  12,  16'h0103});
        vecs.push_back('{10,  4'b0000, 0,  0,   16'h0000});
        vecs.push_back('{7,   4'b0110, 30, 8,   16'h0602});
        vecs.push_back('{252, 4'b0010, 0,  252, 16'h023F});
        vecs.push_back('{260, 4'b0100, 10, 252, 16'h043F});
        vecs.push_back('{253, 4'b1001, 0,  252, 16'h093F});
        vecs.push_back('{3,   4'b1100, 0,  4,   16'h0C01});

        repeat (2) @(negedge clk);
        chk("rst_ready", s_ready, 0);
        chk("rst_data_wr", cell_data_fifo_wr, 0);
        chk("rst_ptr_wr", cell_ptr_fifo_wr, 0);
        chk("rst_err", err_pulse, 0);
        chk("rst_drop", drop_cnt, 0);
        chk("rst_din", cell_data_fifo_din != 0, 0);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        chk("idle_ready", s_ready, 1);

        foreach (vecs[i]) begin
            run_frame(i, vecs[i].len, vecs[i].pm, vecs[i].gap, 1'b0, nwr, desc);
            chk($sformatf("vec%0d_nwr", i), nwr, vecs[i].exp_nwr);
            chk($sformatf("vec%0d_desc", i), desc, vecs[i].exp_desc);
        end

        // Single sof+eof word: ready low through three pads and the descriptor cycle
        clear_mon();
        drive_word(128'h1234, 1'b1, 1'b1, 4'b1000, acc, ok);
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("single_ready_low", s_ready, 0);
        end
        @(negedge clk);
        chk("single_ready_back", s_ready, 1);
        repeat (4) @(negedge clk);
        chk("single_nwr", got_q.size(), 4);
        chk("single_desc", (desc_q.size() > 0) ? desc_q[0] : 16'hDEAD, 16'h0801);

        // Word without sof in idle: dropped with an error pulse
        clear_mon();
        base = err_seen;
        drive_word(128'h55, 1'b0, 1'b0, 4'b0001, acc, ok);
        repeat (4) @(negedge clk);
        chk("nosof_err", err_seen - base, 1);
        chk("nosof_nwr", got_q.size(), 0);

        // Backpressure holds an idle frame but never stalls one in progress
        cell_bp = 1'b1;
        repeat (2) @(negedge clk);
        fork
            run_frame(100, 12, 4'b0110, 0, 1'b0, nwr, desc);
            begin
                for (int i = 0; i < 5; i++) begin
                    @(negedge clk);
                    chk("bp_ready_low", s_ready, 0);
                    chk("bp_no_write", got_q.size(), 0);
                end
                cell_bp = 1'b0;
                repeat (4) @(negedge clk);
                cell_bp = 1'b1;
                repeat (30) @(negedge clk);
                cell_bp = 1'b0;
            end
        join
        chk("bp_desc", desc, 16'h0603);
        if (got_cyc.size() >= 12)
            chk("bp_no_stall", got_cyc[11] - got_cyc[0], 11);
        else
            chk("bp_nwr", got_cyc.size(), 12);

        // Reset in the middle of a frame
        drive_word(128'hA0, 1'b1, 1'b0, 4'b0011, acc, ok);
        drive_word(128'hA1, 1'b0, 1'b0, 4'b0000, acc, ok);
        @(negedge clk);
        s_data = 128'hA2; s_sof = 1'b0; s_eof = 1'b0; s_valid = 1'b1;
        #2 rstn = 1'b0;
        #1;
        chk("midrst_ready", s_ready, 0);
        chk("midrst_data_wr", cell_data_fifo_wr, 0);
        chk("midrst_din", cell_data_fifo_din != 0, 0);
        chk("midrst_ptr_wr", cell_ptr_fifo_wr, 0);
        chk("midrst_ptr_din", cell_ptr_fifo_din, 0);
        chk("midrst_err", err_pulse, 0);
        chk("midrst_drop", drop_cnt, 0);
        s_valid = 1'b0;
        exp_drop = 0;
        @(negedge clk);
        rstn = 1'b1;
        repeat (2) @(negedge clk);
        run_frame(200, 6, 4'b1001, 0, 1'b0, nwr, desc);
        chk("postrst_nwr", nwr, 8);
        chk("postrst_desc", desc, 16'h0902);

        // Random frames: lengths, portmaps, gaps and stray sof flags
        for (int f = 0; f < 40; f++) begin
            int len;
            logic [3:0] pm;
            len = ($urandom_range(9) == 0) ? $urandom_range(250, 258) : $urandom_range(1, 24);
            pm = ($urandom_range(5) == 0) ? 4'd0 : 4'($urandom_range(1, 15));
            run_frame(1000 + f, len, pm, 30, 1'b1, nwr, desc);
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
